// File: rtl/ball_engine.sv
// Ball motion, wall/paddle collision and scoring stage for the pong datapath.
// Consumes paddle centres from the paddle stage each clk1 tick, moves the ball
// one pixel per axis, tracks scores and runs the IDLE/SERVE/PLAY/POINT/OVER FSM.
module ball_engine #(
  parameter int          VGA_H       = 640,
  parameter int          VGA_V       = 480,
  parameter int          BALL_SIZE   = 8,
  parameter int          PAD_W       = 12,
  parameter int          PAD_H       = 80,
  parameter int          WIN_SCORE   = 9,
  parameter int          SERVE_DELAY = 60,
  parameter logic [11:0] BALL_COLOUR = 12'hFFF
) (
  input  logic        clk1,
  input  logic        reset,
  input  logic        serve,
  input  logic [9:0]  xpad1,
  input  logic [9:0]  ypad1,
  input  logic [9:0]  xpad2,
  input  logic [9:0]  ypad2,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [9:0]  xball,
  output logic [9:0]  yball,
  output logic        ball_on,
  output logic [11:0] ball_colour,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Serve counter only needs to reach SERVE_DELAY-1.
  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

  // All geometry is done in 11 bits so sums of 10-bit coordinates never wrap.
  localparam logic [10:0] HALF     = 11'(BALL_SIZE / 2);
  localparam logic [10:0] HALF_M1  = 11'(BALL_SIZE / 2 - 1);
  localparam logic [10:0] PAD_OFF  = 11'(PAD_W / 2 + 1);
  localparam logic [10:0] PAD_HALF = 11'(PAD_H / 2);
  localparam logic [10:0] H_LAST   = 11'(VGA_H - 1);
  localparam logic [10:0] V_LAST   = 11'(VGA_V - 1);
  localparam logic [9:0]  X_CEN    = 10'(VGA_H / 2);
  localparam logic [9:0]  Y_CEN    = 10'(VGA_V / 2);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

  state_t           st;
  logic             dx;
  logic             dy;
  logic             serve_q;
  logic             p1_scored;
  logic [CNT_W-1:0] cnt;

  logic [10:0] xb, yb, xp1, yp1, xp2, yp2, xw, yw;
  logic        press;
  logic        miss_l, miss_r;
  logic        hit_top, hit_bot, hit_l, hit_r;
  logic        vov1, vov2;
  logic        dx_n, dy_n;
  logic [3:0]  sc1_inc, sc2_inc;

  assign xb  = {1'b0, xball};
  assign yb  = {1'b0, yball};
  assign xp1 = {1'b0, xpad1};
  assign yp1 = {1'b0, ypad1};
  assign xp2 = {1'b0, xpad2};
  assign yp2 = {1'b0, ypad2};
  assign xw  = {1'b0, x};
  assign yw  = {1'b0, y};

  // Falling edge of the active-low serve button.
  assign press = !serve && serve_q;

  // Pixel lies inside the ball: L <= x <= R and T <= y <= B, rearranged as sums.
  assign ball_on = (xw + HALF >= xb) && (xw <= xb + HALF_M1) &&
                   (yw + HALF >= yb) && (yw <= yb + HALF_M1);
  assign ball_colour = BALL_COLOUR;

  // Misses: L == 0 or R == VGA_H-1 while heading toward that edge.
  assign miss_l = !dx && (xb == HALF);
  assign miss_r = dx && (xb + HALF_M1 == H_LAST);

  // Walls: T == 0 or B == VGA_V-1 while heading toward that wall.
  assign hit_top = !dy && (yb == HALF);
  assign hit_bot = dy && (yb + HALF_M1 == V_LAST);

  // Vertical overlap of the ball with each paddle: B >= ypad-PAD_H/2 and T <= ypad+PAD_H/2.
  assign vov1 = (yb + HALF_M1 + PAD_HALF >= yp1) && (yb <= yp1 + PAD_HALF + HALF);
  assign vov2 = (yb + HALF_M1 + PAD_HALF >= yp2) && (yb <= yp2 + PAD_HALF + HALF);

  // Paddle faces: L touches the left paddle's right face, R touches the right paddle's left face.
  assign hit_l = !dx && (xb == xp1 + PAD_OFF + HALF) && vov1;
  assign hit_r = dx && (xb + HALF_M1 + PAD_OFF == xp2) && vov2;

  // Direction after this cycle's contacts; the move uses these so there is no dead cycle.
  assign dx_n = hit_l ? 1'b1 : (hit_r ? 1'b0 : dx);
  assign dy_n = hit_top ? 1'b1 : (hit_bot ? 1'b0 : dy);

  // Scores saturate at WIN_SCORE.
  assign sc1_inc = (score1 < WIN) ? score1 + 4'd1 : score1;
  assign sc2_inc = (score2 < WIN) ? score2 + 4'd1 : score2;

  assign state = st;

  // Game FSM with ball position, direction, scores and serve counter.
  always_ff @(posedge clk1) begin
    if (!reset) begin
      st        <= IDLE;
      xball     <= X_CEN;
      yball     <= Y_CEN;
      dx        <= 1'b1;
      dy        <= 1'b1;
      score1    <= '0;
      score2    <= '0;
      game_over <= 1'b0;
      cnt       <= '0;
      serve_q   <= 1'b1;
      p1_scored <= 1'b0;
    end else begin
      serve_q <= serve;
      case (st)
        IDLE: begin
          xball <= X_CEN;
          yball <= Y_CEN;
          if (press) begin
            dx  <= 1'b1;
            dy  <= 1'b1;
            cnt <= '0;
            st  <= SERVE;
          end
        end
        SERVE: begin
          cnt <= cnt + 1'b1;
          if (cnt == SERVE_LAST) st <= PLAY;
        end
        PLAY: begin
          if (miss_l || miss_r) begin
            p1_scored <= miss_r;
            st        <= POINT;
          end else begin
            dx    <= dx_n;
            dy    <= dy_n;
            xball <= dx_n ? xball + 10'd1 : xball - 10'd1;
            yball <= dy_n ? yball + 10'd1 : yball - 10'd1;
          end
        end
        POINT: begin
          xball <= X_CEN;
          yball <= Y_CEN;
          dy    <= 1'b1;
          cnt   <= '0;
          if (p1_scored) begin
            score1 <= sc1_inc;
            dx     <= 1'b1;
            if (sc1_inc == WIN) begin
              st        <= OVER;
              game_over <= 1'b1;
            end else begin
              st <= SERVE;
            end
          end else begin
            score2 <= sc2_inc;
            dx     <= 1'b0;
            if (sc2_inc == WIN) begin
              st        <= OVER;
              game_over <= 1'b1;
            end else begin
              st <= SERVE;
            end
          end
        end
        OVER: begin
          if (press) begin
            score1    <= '0;
            score2    <= '0;
            cnt       <= '0;
            dx        <= 1'b1;
            game_over <= 1'b0;
            st        <= SERVE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: directed sequences for serve, walls,
// paddles, misses, game over and reset, then randomized play against a
// behavioural model written with plain signed integer geometry.
module tb_ball_engine;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int BS = 8;
  localparam int PW = 12;
  localparam int PH = 80;
  localparam int WS = 3;
  localparam int SD = 60;

  logic        clk1 = 1'b0;
  logic        reset = 1'b0;
  logic        serve = 1'b1;
  logic [9:0]  xpad1 = 10'd26, ypad1 = 10'd240, xpad2 = 10'd614, ypad2 = 10'd240;
  logic [9:0]  x = 10'd0, y = 10'd0;
  logic [9:0]  xball, yball;
  logic        ball_on;
  logic [11:0] ball_colour;
  logic [3:0]  score1, score2;
  logic        game_over;
  logic [2:0]  state;

  ball_engine #(
    .VGA_H(H), .VGA_V(V), .BALL_SIZE(BS), .PAD_W(PW), .PAD_H(PH),
    .WIN_SCORE(WS), .SERVE_DELAY(SD), .BALL_COLOUR(12'hFFF)
  ) dut (
    .clk1(clk1), .reset(reset), .serve(serve),
    .xpad1(xpad1), .ypad1(ypad1), .xpad2(xpad2), .ypad2(ypad2),
    .x(x), .y(y),
    .xball(xball), .yball(yball), .ball_on(ball_on), .ball_colour(ball_colour),
    .score1(score1), .score2(score2), .game_over(game_over), .state(state)
  );

  always #5 clk1 = ~clk1;

  // Reference model state (states: 0 idle, 1 serve, 2 play, 3 point, 4 over).
  int m_st, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_cnt, m_sq, m_p1;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int px;
    int py;
    int exp;
  } bo_vec_t;
  bo_vec_t tab[10];

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int model_ball_on(input int px, input int py);
    return (px >= m_x - BS/2 && px <= m_x + BS/2 - 1 &&
            py >= m_y - BS/2 && py <= m_y + BS/2 - 1) ? 1 : 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int press, lft, rgt, top, bot, ndx, ndy, ns;
    int yp1, yp2, xp1, xp2;
    yp1 = int'(ypad1); yp2 = int'(ypad2); xp1 = int'(xpad1); xp2 = int'(xpad2);
    if (!reset) begin
      m_st = 0; m_x = H/2; m_y = V/2; m_dx = 1; m_dy = 1;
      m_s1 = 0; m_s2 = 0; m_cnt = 0; m_sq = 1; m_p1 = 0;
    end else begin
      press = (serve == 1'b0 && m_sq == 1) ? 1 : 0;
      case (m_st)
        0: if (press == 1) begin m_dx = 1; m_dy = 1; m_cnt = 0; m_st = 1; end
        1: begin
          m_cnt++;
          if (m_cnt == SD) m_st = 2;
        end
        2: begin
          lft = m_x - BS/2; rgt = m_x + BS/2 - 1;
          top = m_y - BS/2; bot = m_y + BS/2 - 1;
          if (m_dx == 0 && lft == 0) begin
            m_p1 = 0; m_st = 3;
          end else if (m_dx == 1 && rgt == H - 1) begin
            m_p1 = 1; m_st = 3;
          end else begin
            ndx = m_dx; ndy = m_dy;
            if (m_dy == 0 && top == 0) ndy = 1;
            if (m_dy == 1 && bot == V - 1) ndy = 0;
            if (m_dx == 0 && lft == xp1 + PW/2 + 1 && bot >= yp1 - PH/2 && top <= yp1 + PH/2) ndx = 1;
            if (m_dx == 1 && rgt == xp2 - PW/2 - 1 && bot >= yp2 - PH/2 && top <= yp2 + PH/2) ndx = 0;
            m_dx = ndx; m_dy = ndy;
            m_x = m_x + (ndx == 1 ? 1 : -1);
            m_y = m_y + (ndy == 1 ? 1 : -1);
          end
        end
        3: begin
          m_x = H/2; m_y = V/2; m_dy = 1;
          if (m_p1 == 1) begin
            m_s1 = (m_s1 < WS) ? m_s1 + 1 : WS; m_dx = 1; ns = m_s1;
          end else begin
            m_s2 = (m_s2 < WS) ? m_s2 + 1 : WS; m_dx = 0; ns = m_s2;
          end
          if (ns == WS) m_st = 4;
          else begin m_st = 1; m_cnt = 0; end
        end
        4: if (press == 1) begin m_s1 = 0; m_s2 = 0; m_cnt = 0; m_st = 1; m_dx = 1; end
        default: m_st = 0;
      endcase
      m_sq = int'(serve);
    end
  endtask

  task automatic check_all();
    check("xball", int'(xball), m_x);
    check("yball", int'(yball), m_y);
    check("state", int'(state), m_st);
    check("score1", int'(score1), m_s1);
    check("score2", int'(score2), m_s2);
    check("game_over", int'(game_over), (m_st == 4) ? 1 : 0);
    check("ball_on", int'(ball_on), model_ball_on(int'(x), int'(y)));
    check("ball_colour", int'(ball_colour), 12'hFFF);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk1);
    #1;
    check_all();
  endtask

  // mode 0: both paddles follow the ball; 1: left paddle away; 2: right paddle away.
  task automatic set_pads(input int mode);
    int away;
    away = (m_y < 240) ? 440 : 40;
    ypad1 = 10'((mode == 1) ? away : m_y);
    ypad2 = 10'((mode == 2) ? away : m_y);
  endtask

  // kind 0: state==val; 1: y==val moving down; 2: y==val moving up;
  // 3: x==val moving right; 4: x==val moving left (kinds 1..4 only in play).
  task automatic run_until(input string name, input int kind, input int val,
                           input int mode, input int limit);
    bit found;
    found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      case (kind)
        0: found = (m_st == val);
        1: found = (m_st == 2 && m_y == val && m_dy == 1);
        2: found = (m_st == 2 && m_y == val && m_dy == 0);
        3: found = (m_st == 2 && m_x == val && m_dx == 1);
        default: found = (m_st == 2 && m_x == val && m_dx == 0);
      endcase
      if (!found) begin
        set_pads(mode);
        step();
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout got 0 want 1", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got 0 want 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tab[0] = '{316, 236, 1};
    tab[1] = '{323, 243, 1};
    tab[2] = '{320, 240, 1};
    tab[3] = '{315, 240, 0};
    tab[4] = '{324, 240, 0};
    tab[5] = '{320, 235, 0};
    tab[6] = '{320, 244, 0};
    tab[7] = '{0, 0, 0};
    tab[8] = '{639, 479, 0};
    tab[9] = '{316, 243, 1};

    // Reset held low for two edges, then idle hold.
    reset = 1'b0;
    step();
    step();
    check("rst_xball", int'(xball), 320);
    check("rst_yball", int'(yball), 240);
    check("rst_state", int'(state), 0);
    check("rst_score", int'(score1) + int'(score2), 0);
    reset = 1'b1;
    repeat (100) step();
    check("idle_state", int'(state), 0);
    check("idle_xball", int'(xball), 320);

    // Ball pixel window around the centred ball.
    for (int i = 0; i < 10; i++) begin
      x = 10'(tab[i].px);
      y = 10'(tab[i].py);
      #1;
      check($sformatf("ball_on_tab%0d", i), int'(ball_on), tab[i].exp);
    end

    // Serve launch.
    serve = 1'b0;
    set_pads(0);
    step();
    check("serve_state", int'(state), 1);
    serve = 1'b1;
    repeat (59) step();
    check("serve_hold_state", int'(state), 1);
    check("serve_hold_x", int'(xball), 320);
    step();
    check("play_state", int'(state), 2);
    check("play_x0", int'(xball), 320);
    step();
    check("first_move_x", int'(xball), 321);
    check("first_move_y", int'(yball), 241);
    step();
    check("second_move_x", int'(xball), 322);
    check("second_move_y", int'(yball), 242);

    // Bottom wall.
    run_until("bottom", 1, 476, 0, 2000);
    set_pads(0);
    step();
    check("bottom_bounce_y", int'(yball), 475);

    // Right paddle face.
    run_until("rpad", 3, 604, 0, 2000);
    set_pads(0);
    step();
    check("rpad_bounce_x", int'(xball), 603);

    // Top wall.
    run_until("top", 2, 4, 0, 2000);
    set_pads(0);
    step();
    check("top_bounce_y", int'(yball), 5);

    // Left paddle face.
    run_until("lpad", 4, 37, 0, 2000);
    set_pads(0);
    step();
    check("lpad_bounce_x", int'(xball), 38);

    // Right-hand miss: player 1 scores.
    run_until("miss_r", 0, 3, 2, 3000);
    check("miss_r_state", int'(state), 3);
    check("miss_r_x", int'(xball), 636);
    step();
    check("point_score1", int'(score1), 1);
    check("point_xball", int'(xball), 320);
    check("point_yball", int'(yball), 240);
    check("point_state", int'(state), 1);

    // Three left-hand misses: player 2 reaches the winning score.
    for (int k = 0; k < 3; k++) begin
      run_until("miss_l", 0, 3, 1, 6000);
      step();
    end
    check("over_score2", int'(score2), 3);
    check("over_flag", int'(game_over), 1);
    check("over_state", int'(state), 4);
    repeat (200) step();
    check("over_hold_x", int'(xball), 320);
    check("over_hold_state", int'(state), 4);

    // Restart from OVER.
    serve = 1'b0;
    step();
    check("restart_state", int'(state), 1);
    check("restart_scores", int'(score1) + int'(score2), 0);
    serve = 1'b1;

    // Reset in the middle of play.
    run_until("replay", 0, 2, 0, 200);
    repeat (20) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_state", int'(state), 0);
    check("midrst_x", int'(xball), 320);
    check("midrst_y", int'(yball), 240);
    check("midrst_over", int'(game_over), 0);

    // Randomized play.
    for (int i = 0; i < 8000; i++) begin
      serve = ($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0;
      reset = ($urandom_range(0, 1499) != 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        x = 10'(m_x + int'($urandom_range(0, 15)) - 8);
        y = 10'(m_y + int'($urandom_range(0, 15)) - 8);
      end else begin
        x = 10'($urandom_range(0, 1023));
        y = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 9) == 0) begin
        ypad1 = 10'(m_y + int'($urandom_range(0, 120)) - 60);
        ypad2 = 10'(m_y + int'($urandom_range(0, 120)) - 60);
      end
      step();
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
